// File: rtl/mux_pkg.sv
// Shared definitions for the mux_4to1 slice: select encoding and default width.
package mux_pkg;

  // Select index is {S1,S0}; S1 is the MSB.
  typedef enum logic [1:0] {
    SEL_B0 = 2'b00,
    SEL_B1 = 2'b01,
    SEL_B2 = 2'b10,
    SEL_B3 = 2'b11
  } sel_e;

  localparam int unsigned MUX_WIDTH_DEFAULT = 1;

endpackage : mux_pkg

// File: rtl/mux_2to1.sv
// Two-input multiplexer, WIDTH bits wide.
//   s : select (0 -> a, 1 -> b)
//   a : data selected when s=0
//   b : data selected when s=1
//   y : selected data
module mux_2to1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = s ? b : a;
  end

endmodule : mux_2to1

// File: rtl/mux_4to1.sv
// Four-input multiplexer with optional output register.
//   O      : selected data (registered when REG_OUT=1, 1-cycle latency)
//   S0, S1 : select, index = {S1,S0}
//   B0..B3 : data inputs, Bn selected when {S1,S0}=n
//   clk    : rising-edge clock (REG_OUT=1 only)
//   rst    : synchronous active-high reset, clears O (REG_OUT=1 only)
module mux_4to1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH   = MUX_WIDTH_DEFAULT,
  parameter bit          REG_OUT = 1'b1
) (
  output logic [WIDTH-1:0] O,
  input  logic             S0,
  input  logic             S1,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] B2,
  input  logic [WIDTH-1:0] B3,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] lo_y;
  logic [WIDTH-1:0] hi_y;
  logic [WIDTH-1:0] sel_d;

  // First level on S0 picks within each pair, second level on S1 picks the
  // pair; this reproduces the {S1,S0} index encoding.
  mux_2to1 #(.WIDTH(WIDTH)) u_mux_lo (
    .s (S0),
    .a (B0),
    .b (B1),
    .y (lo_y)
  );

  mux_2to1 #(.WIDTH(WIDTH)) u_mux_hi (
    .s (S0),
    .a (B2),
    .b (B3),
    .y (hi_y)
  );

  mux_2to1 #(.WIDTH(WIDTH)) u_mux_out (
    .s (S1),
    .a (lo_y),
    .b (hi_y),
    .y (sel_d)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] o_d;
      logic [WIDTH-1:0] o_q;

      always_comb begin
        o_d = rst ? '0 : sel_d;
      end

      always_ff @(posedge clk) begin
        o_q <= o_d;
      end

      assign O = o_q;
    end else begin : g_comb
      // clk/rst have no function in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign O = sel_d;
    end
  endgenerate

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
module tb_mux_4to1;
  import mux_pkg::*;

  logic       clk;
  // Registered instance, WIDTH=1
  logic       r_o, r_s0, r_s1, r_b0, r_b1, r_b2, r_b3, r_rst;
  // Combinational instance, WIDTH=8
  logic [7:0] c_o, c_b0, c_b1, c_b2, c_b3;
  logic       c_s0, c_s1, c_rst;

  logic [7:0] sb_r[$];
  logic [7:0] sb_c[$];
  int unsigned n_chk;
  int unsigned n_pass;
  logic [7:0] last_exp_r;

  mux_4to1 #(.WIDTH(1), .REG_OUT(1'b1)) u_dut_reg (
    .O   (r_o),
    .S0  (r_s0),
    .S1  (r_s1),
    .B0  (r_b0),
    .B1  (r_b1),
    .B2  (r_b2),
    .B3  (r_b3),
    .clk (clk),
    .rst (r_rst)
  );

  mux_4to1 #(.WIDTH(8), .REG_OUT(1'b0)) u_dut_comb (
    .O   (c_o),
    .S0  (c_s0),
    .S1  (c_s1),
    .B0  (c_b0),
    .B1  (c_b1),
    .B2  (c_b2),
    .B3  (c_b3),
    .clk (clk),
    .rst (c_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic pop_check(input string tag, inout logic [7:0] q[$], input logic [7:0] obs);
    logic [7:0] e;
    if (q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = q.pop_front();
      check_val(tag, obs, e);
    end
  endtask

  // Drive the registered instance just after an edge; its expected value is
  // observed after the following rising edge.
  task automatic drive_r(input string tag, input logic rst_v, input sel_e s,
                         input logic [3:0] b, input logic hold_check);
    logic [7:0] e;
    logic [1:0] idx;
    idx = s;
    r_rst = rst_v;
    {r_s1, r_s0} = s;
    {r_b3, r_b2, r_b1, r_b0} = b;
    e = rst_v ? 8'h00 : {7'b0, b[idx]};
    sb_r.push_back(e);
    if (hold_check) begin
      #2;
      check_val({tag, "_hold"}, {7'b0, r_o}, last_exp_r);
    end
    @(posedge clk);
    #1;
    pop_check(tag, sb_r, {7'b0, r_o});
    last_exp_r = e;
  endtask

  task automatic drive_c(input string tag, input logic rst_v, input sel_e s);
    logic [1:0] idx;
    logic [7:0] bv[4];
    bv[0] = c_b0; bv[1] = c_b1; bv[2] = c_b2; bv[3] = c_b3;
    idx = s;
    c_rst = rst_v;
    {c_s1, c_s0} = s;
    sb_c.push_back(bv[idx]);
    #1;
    pop_check(tag, sb_c, c_o);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    last_exp_r = 8'h00;
    c_rst = 1'b0;
    c_s0 = 1'b0; c_s1 = 1'b0;
    c_b0 = 8'h11; c_b1 = 8'h22; c_b2 = 8'h44; c_b3 = 8'h88;

    // Reset held two cycles with a select that would otherwise give 1
    drive_r("rst0", 1'b1, SEL_B3, 4'b1010, 1'b0);
    drive_r("rst1", 1'b1, SEL_B3, 4'b1010, 1'b0);
    drive_r("rst_rel", 1'b0, SEL_B3, 4'b1010, 1'b0);

    // Data set A: B3..B0 = 1,0,1,0
    drive_r("a_00", 1'b0, SEL_B0, 4'b1010, 1'b0);
    drive_r("a_10", 1'b0, SEL_B2, 4'b1010, 1'b0);
    drive_r("a_01", 1'b0, SEL_B1, 4'b1010, 1'b0);
    drive_r("a_11", 1'b0, SEL_B3, 4'b1010, 1'b0);

    // Data set B: B3..B0 = 1,0,0,1
    drive_r("b_00", 1'b0, SEL_B0, 4'b1001, 1'b0);
    drive_r("b_10", 1'b0, SEL_B2, 4'b1001, 1'b0);
    drive_r("b_01", 1'b0, SEL_B1, 4'b1001, 1'b0);
    drive_r("b_11", 1'b0, SEL_B3, 4'b1001, 1'b0);

    // Mid-operation reset pulse
    drive_r("mr_pre", 1'b0, SEL_B3, 4'b1001, 1'b0);
    drive_r("mr_rst", 1'b1, SEL_B3, 4'b1001, 1'b0);
    drive_r("mr_post", 1'b0, SEL_B3, 4'b1001, 1'b0);

    // Latency: settle on B0=0, then switch select to 11 with B3=1
    drive_r("lat_pre", 1'b0, SEL_B0, 4'b1000, 1'b0);
    drive_r("lat", 1'b0, SEL_B3, 4'b1000, 1'b1);

    // Combinational instance: zero latency, rst ignored
    drive_c("c_00", 1'b0, SEL_B0);
    drive_c("c_01", 1'b0, SEL_B1);
    drive_c("c_10", 1'b0, SEL_B2);
    drive_c("c_11", 1'b0, SEL_B3);
    drive_c("c_rst_00", 1'b1, SEL_B0);
    drive_c("c_rst_01", 1'b1, SEL_B1);
    drive_c("c_rst_10", 1'b1, SEL_B2);
    drive_c("c_rst_11", 1'b1, SEL_B3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_mux_4to1
